// File: rtl/trig_sequencer.sv
// trig_sequencer
//   Turns the first qualified trigger edge (ADC0, ADC1 or external) into a
//   fixed-length capture window, holds the event for the readout handshake,
//   then waits out a holdoff period and re-arms or returns to idle.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   arm                   one-cycle arm request (IDLE only)
//   abort                 return to IDLE from any state (highest priority)
//   auto_rearm            1: ARMED after holdoff, 0: IDLE after holdoff
//   trig_mask[2:0]        per-source enable: [0]=ADC0 [1]=ADC1 [2]=external
//   trg_in[2:0]           trigger levels, same bit order as trig_mask
//   read_done             readout-complete pulse (READOUT only)
//   armed                 high while waiting for a trigger
//   cap_en                capture-buffer write enable (POSTTRG cycles)
//   cap_done              event ready for readout (level)
//   busy                  high in CAPTURE, READOUT and HOLDOFF
//   trig_src[2:0]         qualified sources on the accepted trigger cycle
//   trig_cnt[CNT_W-1:0]   accepted triggers, wraps
//   miss_cnt[CNT_W-1:0]   qualified-edge cycles seen while busy, saturates
module trig_sequencer #(
    parameter int unsigned POSTTRG = 64,
    parameter int unsigned HOLDOFF = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic             auto_rearm,
    input  logic [2:0]       trig_mask,
    input  logic [2:0]       trg_in,
    input  logic             read_done,
    output logic             armed,
    output logic             cap_en,
    output logic             cap_done,
    output logic             busy,
    output logic [2:0]       trig_src,
    output logic [CNT_W-1:0] trig_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_READOUT = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    // Timer is loaded with "length - 1" and the state exits when it reaches zero.
    localparam logic [15:0]      POST_LAST = 16'(POSTTRG - 32'd1);
    localparam logic [15:0]      HOLD_LAST = 16'(HOLDOFF - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [15:0]      timer_q;
    logic [2:0]       prev_q;
    logic             armed_q;
    logic             cap_en_q;
    logic             cap_done_q;
    logic             busy_q;
    logic [2:0]       trig_src_q;
    logic [CNT_W-1:0] trig_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;
    logic [CNT_W-1:0] miss_cnt_d;

    logic [2:0]       qual_s;
    logic             any_qual_s;
    logic             busy_state_s;

    assign qual_s     = trg_in & ~prev_q & trig_mask;
    assign any_qual_s = |qual_s;

    // Flag the states in which a qualified edge counts as missed.
    always_comb begin
        busy_state_s = 1'b0;
        case (state_q)
            S_CAPTURE: busy_state_s = 1'b1;
            S_READOUT: busy_state_s = 1'b1;
            S_HOLDOFF: busy_state_s = 1'b1;
            default:   busy_state_s = 1'b0;
        endcase
    end

    // Saturating miss counter next value; counted even in an abort cycle.
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (busy_state_s && any_qual_s && (miss_cnt_q != CNT_MAX)) begin
            miss_cnt_d = miss_cnt_q + CNT_ONE;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Sequencer FSM with registered outputs and trigger history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= 16'd0;
            prev_q     <= 3'b111;   // a level already high at release is not an edge
            armed_q    <= 1'b0;
            cap_en_q   <= 1'b0;
            cap_done_q <= 1'b0;
            busy_q     <= 1'b0;
            trig_src_q <= 3'b000;
            trig_cnt_q <= {CNT_W{1'b0}};
            miss_cnt_q <= {CNT_W{1'b0}};
        end else begin
            prev_q     <= trg_in;
            miss_cnt_q <= miss_cnt_d;
            if (abort) begin
                // Event bookkeeping (trig_src, counters) survives an abort.
                state_q    <= S_IDLE;
                armed_q    <= 1'b0;
                cap_en_q   <= 1'b0;
                cap_done_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (arm) begin
                            state_q <= S_ARMED;
                            armed_q <= 1'b1;
                        end
                    end
                    S_ARMED: begin
                        if (any_qual_s) begin
                            state_q    <= S_CAPTURE;
                            armed_q    <= 1'b0;
                            cap_en_q   <= 1'b1;
                            busy_q     <= 1'b1;
                            trig_src_q <= qual_s;
                            trig_cnt_q <= trig_cnt_q + CNT_ONE;
                            timer_q    <= POST_LAST;
                        end
                    end
                    S_CAPTURE: begin
                        if (timer_q == 16'd0) begin
                            state_q    <= S_READOUT;
                            cap_en_q   <= 1'b0;
                            cap_done_q <= 1'b1;
                        end else begin
                            timer_q <= timer_q - 16'd1;
                        end
                    end
                    S_READOUT: begin
                        if (read_done) begin
                            cap_done_q <= 1'b0;
                            if (HOLDOFF == 32'd0) begin
                                state_q <= auto_rearm ? S_ARMED : S_IDLE;
                                armed_q <= auto_rearm;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= S_HOLDOFF;
                                timer_q <= HOLD_LAST;
                            end
                        end
                    end
                    S_HOLDOFF: begin
                        if (timer_q == 16'd0) begin
                            state_q <= auto_rearm ? S_ARMED : S_IDLE;
                            armed_q <= auto_rearm;
                            busy_q  <= 1'b0;
                        end else begin
                            timer_q <= timer_q - 16'd1;
                        end
                    end
                    default: begin
                        state_q    <= S_IDLE;
                        armed_q    <= 1'b0;
                        cap_en_q   <= 1'b0;
                        cap_done_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign armed    = armed_q;
    assign cap_en   = cap_en_q;
    assign cap_done = cap_done_q;
    assign busy     = busy_q;
    assign trig_src = trig_src_q;
    assign trig_cnt = trig_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_trig_sequencer.sv
`timescale 1ns/1ps
module tb_trig_sequencer;

    localparam int unsigned PA = 64, HA = 16, WA = 16;
    localparam int unsigned PB = 5,  HB = 0,  WB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arm = 1'b0, abort = 1'b0, auto_rearm = 1'b0, read_done = 1'b0;
    logic [2:0] trig_mask = 3'b000, trg_in = 3'b000;

    logic armed_a, cap_en_a, cap_done_a, busy_a;
    logic [2:0] trig_src_a;
    logic [WA-1:0] trig_cnt_a, miss_cnt_a;
    logic armed_b, cap_en_b, cap_done_b, busy_b;
    logic [2:0] trig_src_b;
    logic [WB-1:0] trig_cnt_b, miss_cnt_b;

    always #5 clk = ~clk;

    trig_sequencer #(.POSTTRG(PA), .HOLDOFF(HA), .CNT_W(WA)) dut_a (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .auto_rearm(auto_rearm),
        .trig_mask(trig_mask), .trg_in(trg_in), .read_done(read_done),
        .armed(armed_a), .cap_en(cap_en_a), .cap_done(cap_done_a), .busy(busy_a),
        .trig_src(trig_src_a), .trig_cnt(trig_cnt_a), .miss_cnt(miss_cnt_a));

    trig_sequencer #(.POSTTRG(PB), .HOLDOFF(HB), .CNT_W(WB)) dut_b (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .auto_rearm(auto_rearm),
        .trig_mask(trig_mask), .trg_in(trg_in), .read_done(read_done),
        .armed(armed_b), .cap_en(cap_en_b), .cap_done(cap_done_b), .busy(busy_b),
        .trig_src(trig_src_b), .trig_cnt(trig_cnt_b), .miss_cnt(miss_cnt_b));

    typedef struct packed {
        logic        armed;
        logic        cap_en;
        logic        cap_done;
        logic        busy;
        logic [2:0]  src;
        logic [15:0] tcnt;
        logic [15:0] miss;
    } obs_t;

    obs_t obs_a, obs_b, ea, eb;
    assign obs_a = {armed_a, cap_en_a, cap_done_a, busy_a, trig_src_a, trig_cnt_a, miss_cnt_a};
    assign obs_b = {armed_b, cap_en_b, cap_done_b, busy_b, trig_src_b,
                    12'h000, trig_cnt_b, 12'h000, miss_cnt_b};

    obs_t qa[$];
    obs_t qb[$];
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model (event/timestamp level) ----------------
    localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_READ = 3, M_HOLD = 4;
    int          m_mode [2];
    longint      m_t0   [2];
    logic [2:0]  m_prev [2];
    logic [2:0]  m_src  [2];
    int unsigned m_tcnt [2];
    int unsigned m_miss [2];
    longint      cyc_n = 0;

    task automatic model_step(input int k, input int unsigned post, input int unsigned hold,
                              input int unsigned w, input longint cyc);
        logic [2:0]  q;
        int unsigned lim;
        lim = 32'd1 << w;
        if (rst) begin
            m_mode[k] = M_IDLE; m_prev[k] = 3'b111; m_src[k] = 3'b000;
            m_tcnt[k] = 0; m_miss[k] = 0; m_t0[k] = 0;
        end else begin
            q = trg_in & ~m_prev[k] & trig_mask;
            m_prev[k] = trg_in;
            if (m_mode[k] >= M_CAP && q != 3'b000 && m_miss[k] < lim - 1) m_miss[k]++;
            if (abort) m_mode[k] = M_IDLE;
            else if (m_mode[k] == M_IDLE) begin
                if (arm) m_mode[k] = M_ARMED;
            end else if (m_mode[k] == M_ARMED) begin
                if (q != 3'b000) begin
                    m_mode[k] = M_CAP; m_src[k] = q;
                    m_tcnt[k] = (m_tcnt[k] + 1) % lim; m_t0[k] = cyc;
                end
            end else if (m_mode[k] == M_CAP) begin
                if (cyc - m_t0[k] == longint'(post)) m_mode[k] = M_READ;
            end else if (m_mode[k] == M_READ) begin
                if (read_done) begin
                    if (hold == 0) m_mode[k] = auto_rearm ? M_ARMED : M_IDLE;
                    else begin m_mode[k] = M_HOLD; m_t0[k] = cyc; end
                end
            end else begin
                if (cyc - m_t0[k] == longint'(hold)) m_mode[k] = auto_rearm ? M_ARMED : M_IDLE;
            end
        end
    endtask

    function automatic obs_t mk(input int k);
        obs_t o;
        o.armed    = (m_mode[k] == M_ARMED);
        o.cap_en   = (m_mode[k] == M_CAP);
        o.cap_done = (m_mode[k] == M_READ);
        o.busy     = (m_mode[k] >= M_CAP);
        o.src      = m_src[k];
        o.tcnt     = 16'(m_tcnt[k]);
        o.miss     = 16'(m_miss[k]);
        return o;
    endfunction

    // model: advance on every clock edge and queue the expected outputs
    initial begin
        forever begin
            @(posedge clk);
            cyc_n++;
            model_step(0, PA, HA, WA, cyc_n);
            model_step(1, PB, HB, WB, cyc_n);
            qa.push_back(mk(0));
            qb.push_back(mk(1));
        end
    end

    // monitor: pop and compare on the opposite edge
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (qa.size() == 0 || qb.size() == 0) begin
                chk("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk("dut_a_outputs", obs_a, ea);
                chk("dut_b_outputs", obs_b, eb);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_arm();
        arm = 1'b1; cyc(1); arm = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1; cyc(1); abort = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_a", obs_a, 64'd0);
        chk("rst_async_b", obs_b, 64'd0);
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic run_count(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            cyc(1);
            if (cap_en_a) cnt++;
        end
    endtask

    int c, guard;

    initial begin
        cyc(2);

        // basic event
        do_reset();
        trig_mask = 3'b001; auto_rearm = 1'b0;
        pulse_arm();
        cyc(4);
        trg_in = 3'b001;
        run_count(80, c);
        trg_in = 3'b000;
        chk("s1_window_len", c, 64);
        chk("s1_cap_done", cap_done_a, 1'b1);
        read_done = 1'b1; cyc(1); read_done = 1'b0;
        chk("s1_cap_done_drop", cap_done_a, 1'b0);
        chk("s1_busy_holdoff", busy_a, 1'b1);
        cyc(20);
        chk("s1_idle", {armed_a, cap_en_a, cap_done_a, busy_a}, 4'b0000);
        chk("s1_trig_cnt", trig_cnt_a, 16'd1);
        chk("s1_trig_src", trig_src_a, 3'b001);

        // simultaneous sources
        do_reset();
        trig_mask = 3'b111;
        pulse_arm();
        cyc(2);
        trg_in = 3'b011;
        run_count(80, c);
        chk("s2_window_len", c, 64);
        chk("s2_trig_src", trig_src_a, 3'b011);
        chk("s2_trig_cnt", trig_cnt_a, 16'd1);
        pulse_abort();
        trg_in = 3'b000;

        // masked and missed edges
        do_reset();
        trig_mask = 3'b010;
        pulse_arm();
        cyc(2);
        trg_in = 3'b001; cyc(1); trg_in = 3'b000; cyc(3);
        chk("s3_still_armed", armed_a, 1'b1);
        chk("s3_no_trig", trig_cnt_a, 16'd0);
        trg_in = 3'b010; cyc(1); trg_in = 3'b000; cyc(1);
        for (int i = 0; i < 3; i++) begin
            trg_in = 3'b010; cyc(1); trg_in = 3'b000; cyc(1);
        end
        cyc(5);
        chk("s3_miss_cnt", miss_cnt_a, 16'd3);
        chk("s3_trig_cnt", trig_cnt_a, 16'd1);
        chk("s3_capturing", cap_en_a, 1'b1);
        pulse_abort();

        // auto re-arm with zero holdoff (dut_b)
        do_reset();
        trig_mask = 3'b001; auto_rearm = 1'b1;
        pulse_arm();
        cyc(1);
        trg_in = 3'b001; cyc(1); trg_in = 3'b000;
        cyc(8);
        chk("s4_b_readout", cap_done_b, 1'b1);
        read_done = 1'b1; cyc(1); read_done = 1'b0;
        chk("s4_b_rearmed", armed_b, 1'b1);
        chk("s4_b_not_busy", busy_b, 1'b0);
        cyc(2);
        trg_in = 3'b001; cyc(1); trg_in = 3'b000; cyc(2);
        chk("s4_b_trig_cnt", trig_cnt_b, 4'd2);
        chk("s4_b_capturing", cap_en_b, 1'b1);
        chk("s4_a_missed", miss_cnt_a, 16'd1);
        pulse_abort();
        auto_rearm = 1'b0;

        // abort mid-capture
        do_reset();
        trig_mask = 3'b001;
        pulse_arm();
        trg_in = 3'b001;
        c = 0; guard = 0;
        while (c < 20 && guard < 100) begin
            cyc(1); guard++;
            if (cap_en_a) c++;
        end
        trg_in = 3'b000;
        chk("s5_reached_20", c, 20);
        pulse_abort();
        chk("s5_cap_en_off", cap_en_a, 1'b0);
        chk("s5_idle", {armed_a, busy_a, cap_done_a}, 3'b000);
        chk("s5_keep_cnt", trig_cnt_a, 16'd1);
        chk("s5_keep_src", trig_src_a, 3'b001);
        cyc(2);
        pulse_arm();
        trg_in = 3'b001; cyc(3); trg_in = 3'b000;
        chk("s5_rearm_cnt", trig_cnt_a, 16'd2);
        chk("s5_rearm_cap", cap_en_a, 1'b1);
        pulse_abort();

        // level high through reset release, then reset during readout
        trig_mask = 3'b100; trg_in = 3'b100;
        do_reset();
        pulse_arm();
        cyc(5);
        chk("s6_no_trig_armed", armed_a, 1'b1);
        chk("s6_no_trig_cnt", trig_cnt_a, 16'd0);
        trg_in = 3'b000; cyc(2);
        trg_in = 3'b100; cyc(2);
        chk("s6_trig_cap", cap_en_a, 1'b1);
        chk("s6_trig_cnt", trig_cnt_a, 16'd1);
        chk("s6_trig_src", trig_src_a, 3'b100);
        cyc(70);
        chk("s6_in_readout", cap_done_a, 1'b1);
        do_reset();

        // randomized traffic against the model
        trig_mask = 3'b111; auto_rearm = 1'b1; trg_in = 3'b000;
        for (int i = 0; i < 4000; i++) begin
            arm       = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 99) == 0);
            read_done = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) auto_rearm = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 127) == 0) trig_mask = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) trg_in = trg_in ^ 3'($urandom_range(0, 7));
            if ($urandom_range(0, 999) == 0) do_reset();
            else cyc(1);
        end
        arm = 1'b0; abort = 1'b0; read_done = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
